cpu6_ibuf: RTL
==============

Name: cpu6_ibuf

Overview:
- Instruction buffer between the cpu6 fetch unit and the decode stage (cpu6_maindec and the register-index and immediate extractors).
- Holds up to DEPTH fetched instructions with their PC and fetch-error flag. Decouples fetch from decode stalls with a valid/ready handshake on both sides.
- Presents pre-split decode fields (opcode, funct3, funct7, register indices) to decode.
- Substitutes a canonical NOP whenever it is empty or flushed, because all-zero instructions decode as illegal.

Parameters:
- DEPTH, 2, number of buffer entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, do not override.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  redirect/exception flush; discards all entries and any same-cycle push.
- ifu_valid  in  1  fetch presents an instruction.
- ifu_ready  out  1  buffer can accept; registered, equals (count != DEPTH).
- ifu_pc  in  32  PC of the presented instruction.
- ifu_instr  in  32  instruction word.
- ifu_err  in  1  fetch bus error for this word.
- dec_valid  out  1  head entry is valid.
- dec_ready  in  1  decode consumes the head this cycle.
- dec_pc  out  32  head PC; 0 when empty.
- dec_instr  out  32  head instruction; `CPU6_NOP_INSTR when empty.
- dec_op  out  `CPU6_OPCODE_SIZE  dec_instr[6:0].
- dec_funct3  out  `CPU6_FUNCT3_SIZE  dec_instr[14:12].
- dec_funct7  out  `CPU6_FUNCT7_SIZE  dec_instr[31:25].
- dec_rs1  out  5  dec_instr[19:15].
- dec_rs2  out  5  dec_instr[24:20].
- dec_rd  out  5  dec_instr[11:7].
- dec_ferr  out  1  head fetch error; 0 when empty.
- count  out  PTR_W+1  current occupancy.

Behaviour:
- Reset (async, active-high): wptr=0, rptr=0, count=0. Consequently ifu_ready=1, dec_valid=0, dec_instr=NOP (32'h0000_0013), dec_pc=0, dec_ferr=0. Entry storage needs no reset.
- Push = ifu_valid & ifu_ready & ~flush. Writes {pc, instr, err} to entry[wptr]; wptr increments modulo DEPTH.
- Pop = dec_valid & dec_ready & ~flush. rptr increments modulo DEPTH.
- Count update: push only → +1; pop only → -1; both → unchanged; neither → unchanged.
- Latency:
  - Write to read is at least one cycle; there is no fetch-to-decode combinational bypass.
  - An instruction pushed in cycle N is visible on dec_* in cycle N+1 at the earliest.
- dec_valid = (count != 0). dec_* are driven combinationally from entry[rptr], masked to NOP/0/0 when count==0.
- ifu_ready depends only on count, never on dec_ready. When full, no push occurs even if a pop happens in the same cycle. The full→accept transition takes effect the cycle after the pop.
- Flush has the highest priority. Next cycle: wptr=rptr=0, count=0, dec_valid=0. A same-cycle push and pop are both suppressed.
- Flush while empty has no effect beyond holding the reset state.
- Pointer wrap: the DEPTH-1→0 wrap is natural for power-of-two DEPTH. Full and empty are distinguished solely by count.
- Reset asserted mid-operation discards all entries immediately (asynchronous). The first push is accepted on the first clk edge after reset deasserts.
- Decode-field outputs are pure slices of dec_instr, so an empty buffer yields the ADDI x0,x0,0 fields: op=0010011, funct3=000, rd=rs1=0. maindec therefore sees a legal, side-effect-free instruction.
- Non-32-bit encodings (instr[1:0]!=2'b11) are stored unchanged; illegality is decode's responsibility.
- The fetch-error flag travels with its entry and is never merged with neighbouring entries.

Decomposition:
- defines.v gains:
  - `CPU6_NOP_INSTR (32'h0000_0013).
  - `CPU6_IBUF_DEPTH (default 2).
  - `CPU6_RS_SIZE (5), used for the dec_rs1/rs2/rd widths.
- Existing `CPU6_OPCODE_SIZE/FUNCT3/FUNCT7 are reused.
- No sub-module: the storage is a small register array inside the block.

Test Plan:
- Reset then idle: after reset release, 3 cycles with ifu_valid=0 → dec_valid=0, dec_instr=32'h00000013, dec_op=7'b0010011, ifu_ready=1, count=0.
- Single pass: push pc=0x100, instr=0x00500093 in cycle 1 → cycle 2: dec_valid=1, dec_pc=0x100, dec_rd=1, dec_funct3=0; with dec_ready=1, count returns to 0 in cycle 3.
- Fill and stall: dec_ready=0, push 0x100/0x104/0x108 back-to-back → first two accepted, ifu_ready=0 after the second, count=2, third not accepted. Then dec_ready=1 → head 0x100 pops, ifu_ready=1 next cycle, 0x108 accepted after that, order preserved 0x100, 0x104, 0x108.
- Simultaneous push+pop at count=1 for 8 cycles with PCs incrementing by 4 → count stays 1, dec_pc sequence exactly one cycle behind ifu_pc, pointers wrap without loss.
- Flush priority: count=2 with flush=1, ifu_valid=1 (pc 0x200) and dec_ready=1 in the same cycle → next cycle count=0, dec_valid=0, dec_instr=NOP; 0x200 never appears on dec_pc.
- Error tagging and async reset: push 0x300 with ifu_err=1, then 0x304 with ifu_err=0 → dec_ferr reads 1 then 0. Asserting reset mid-cycle with count=2 → dec_valid drops to 0 without waiting for a clk edge.

Source files
------------

// File: rtl/cpu6_ibuf_pkg.sv
// Shared sizes, canonical NOP and decode-field helpers for the cpu6 instruction buffer.
// Imported by the interface and the buffer so both agree on field widths.
package cpu6_ibuf_pkg;

  localparam int CPU6_OPCODE_SIZE = 7;
  localparam int CPU6_FUNCT3_SIZE = 3;
  localparam int CPU6_FUNCT7_SIZE = 7;
  localparam int CPU6_RS_SIZE     = 5;
  localparam int CPU6_IBUF_DEPTH  = 2;

  // ADDI x0,x0,0: all-zero words decode as illegal, so an empty slot shows this.
  localparam logic [31:0] CPU6_NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } ibuf_entry_t;

  typedef struct packed {
    logic [CPU6_OPCODE_SIZE-1:0] op;
    logic [CPU6_FUNCT3_SIZE-1:0] funct3;
    logic [CPU6_FUNCT7_SIZE-1:0] funct7;
    logic [CPU6_RS_SIZE-1:0]     rs1;
    logic [CPU6_RS_SIZE-1:0]     rs2;
    logic [CPU6_RS_SIZE-1:0]     rd;
  } dec_fields_t;

  function automatic dec_fields_t cpu6_split_instr(input logic [31:0] instr);
    dec_fields_t f;
    f.op     = instr[6:0];
    f.funct3 = instr[14:12];
    f.funct7 = instr[31:25];
    f.rs1    = instr[19:15];
    f.rs2    = instr[24:20];
    f.rd     = instr[11:7];
    return f;
  endfunction

endpackage

// File: rtl/cpu6_ibuf_if.sv
// Fetch-side and decode-side handshake bundle of the instruction buffer.
// slave = the buffer itself; master = whoever drives fetch and decode (core glue or bench).
interface cpu6_ibuf_if
  import cpu6_ibuf_pkg::*;
#(
  parameter int DEPTH = CPU6_IBUF_DEPTH
);
  localparam int PTR_W = $clog2(DEPTH);

  logic                        flush;
  logic                        ifu_valid;
  logic                        ifu_ready;
  logic [31:0]                 ifu_pc;
  logic [31:0]                 ifu_instr;
  logic                        ifu_err;
  logic                        dec_valid;
  logic                        dec_ready;
  logic [31:0]                 dec_pc;
  logic [31:0]                 dec_instr;
  logic [CPU6_OPCODE_SIZE-1:0] dec_op;
  logic [CPU6_FUNCT3_SIZE-1:0] dec_funct3;
  logic [CPU6_FUNCT7_SIZE-1:0] dec_funct7;
  logic [CPU6_RS_SIZE-1:0]     dec_rs1;
  logic [CPU6_RS_SIZE-1:0]     dec_rs2;
  logic [CPU6_RS_SIZE-1:0]     dec_rd;
  logic                        dec_ferr;
  logic [PTR_W:0]              count;

  modport slave (
    input  flush, ifu_valid, ifu_pc, ifu_instr, ifu_err, dec_ready,
    output ifu_ready, dec_valid, dec_pc, dec_instr, dec_op, dec_funct3, dec_funct7,
           dec_rs1, dec_rs2, dec_rd, dec_ferr, count
  );

  modport master (
    output flush, ifu_valid, ifu_pc, ifu_instr, ifu_err, dec_ready,
    input  ifu_ready, dec_valid, dec_pc, dec_instr, dec_op, dec_funct3, dec_funct7,
           dec_rs1, dec_rs2, dec_rd, dec_ferr, count
  );

endinterface

// File: rtl/cpu6_ibuf.sv
// cpu6 instruction buffer: DEPTH-entry FIFO between fetch and decode, no bypass path,
// presenting pre-split decode fields and a canonical NOP whenever it holds nothing.
module cpu6_ibuf
  import cpu6_ibuf_pkg::*;
#(
  parameter int DEPTH = CPU6_IBUF_DEPTH
) (
  input logic        clk,
  input logic        reset,
  cpu6_ibuf_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             r_ifu_ready;
  ibuf_entry_t      r_mem [DEPTH];

  logic [PTR_W-1:0] w_wptr_nxt;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [PTR_W:0]   w_count_nxt;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  ibuf_entry_t      w_head;
  logic [31:0]      w_instr;
  dec_fields_t      w_fields;

  assign w_empty = (r_count == '0);
  // ifu_ready is the registered copy of (count != DEPTH), so a pop never frees a slot same-cycle.
  assign w_push  = bus.ifu_valid & r_ifu_ready & ~bus.flush;
  assign w_pop   = ~w_empty & bus.dec_ready & ~bus.flush;

  always_comb begin
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    if (bus.flush) begin
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      if (w_push) w_wptr_nxt = r_wptr + PTR_ONE;
      if (w_pop)  w_rptr_nxt = r_rptr + PTR_ONE;
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_ONE;
        2'b01:   w_count_nxt = r_count - CNT_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // ---- control state: pointers, occupancy, fetch-side ready ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_ifu_ready <= 1'b1;
    end else begin
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_count     <= w_count_nxt;
      r_ifu_ready <= (w_count_nxt != CNT_FULL);
    end
  end

  // ---- entry storage: data only, contents are meaningless until counted ----
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{pc: bus.ifu_pc, instr: bus.ifu_instr, err: bus.ifu_err};
    end
  end

  // ---- decode-side view of the head entry ----
  assign w_head   = r_mem[r_rptr];
  assign w_instr  = w_empty ? CPU6_NOP_INSTR : w_head.instr;
  assign w_fields = cpu6_split_instr(w_instr);

  assign bus.ifu_ready  = r_ifu_ready;
  assign bus.count      = r_count;
  assign bus.dec_valid  = ~w_empty;
  assign bus.dec_pc     = w_empty ? 32'h0 : w_head.pc;
  assign bus.dec_ferr   = ~w_empty & w_head.err;
  assign bus.dec_instr  = w_instr;
  assign bus.dec_op     = w_fields.op;
  assign bus.dec_funct3 = w_fields.funct3;
  assign bus.dec_funct7 = w_fields.funct7;
  assign bus.dec_rs1    = w_fields.rs1;
  assign bus.dec_rs2    = w_fields.rs2;
  assign bus.dec_rd     = w_fields.rd;

endmodule
